// File: rtl/ps2_key_framer.sv
// ps2_key_framer
// PS/2 keyboard receiver for the clk_sys domain.
// - Synchronises the raw PS/2 clock and data lines.
// - Filters the clock and uses each falling edge of the filtered clock as a bit strobe.
// - Deserialises 11-bit frames and assembles the bytes of multi-byte key sequences
//   (E0/F0 prefixes, Print Screen, Pause) into a single 65-bit event word.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   : a bad odd-parity bit drops the frame and pulses err.
//   undefined : the parity bit is clocked past and ignored.
module ps2_key_framer #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [64:0] ps2_key,
    output logic        err,
    output logic        busy
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [TW-1:0] TO_ONE    = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } frame_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Synchroniser, filter and edge detect
    logic          clk_meta_r, clk_sync_r;
    logic          dat_meta_r, dat_sync_r;
    logic [FW-1:0] filt_cnt_r;
    logic          filt_r, filt_d_r;
    logic          strobe_s;

    // Frame deserialiser
    frame_state_t  state_r, state_nx_s;
    logic [2:0]    bit_cnt_r, bit_cnt_nx_s;
    logic [7:0]    shift_r, shift_nx_s;
    logic          byte_ok_s, frame_err_s;

    // Sequence assembly
    logic [63:0]   acc_r, acc_nx_s, acc_shift_s;
    logic          seq_r, seq_nx_s;
    logic          pause_r, pause_nx_s;
    logic [2:0]    pcnt_r, pcnt_nx_s;
    logic          hold_s;

    // Outputs and timeout
    logic [64:0]   ps2_key_r, key_nx_s;
    logic          err_r, err_nx_s;
    logic          busy_r, busy_nx_s;
    logic [TW-1:0] to_cnt_r, to_cnt_nx_s;
    logic          timeout_s;

    // Two-flop synchronisers for the asynchronous PS/2 lines (idle level is high).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Clock filter: the filtered level follows only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_r <= {FW{1'b0}};
            filt_r     <= 1'b1;
            filt_d_r   <= 1'b1;
        end else begin
            filt_d_r <= filt_r;
            if (clk_sync_r == filt_r) begin
                filt_cnt_r <= {FW{1'b0}};
            end else if (filt_cnt_r == FILT_LAST) begin
                filt_r     <= clk_sync_r;
                filt_cnt_r <= {FW{1'b0}};
            end else begin
                filt_cnt_r <= filt_cnt_r + FILT_ONE;
            end
        end
    end

    assign strobe_s  = filt_d_r & ~filt_r;
    assign timeout_s = busy_r && (to_cnt_r == TO_LIMIT);

    // Frame FSM next state: shifts data LSB first and flags a good byte or a framing error.
    always_comb begin
        state_nx_s   = state_r;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        byte_ok_s    = 1'b0;
        frame_err_s  = 1'b0;
        if (timeout_s) begin
            state_nx_s   = ST_IDLE;
            bit_cnt_nx_s = 3'd0;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!dat_sync_r) begin
                        state_nx_s   = ST_DATA;
                        bit_cnt_nx_s = 3'd0;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_nx_s   = {dat_sync_r, shift_r[7:1]};
                    bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nx_s = ST_PARITY;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    if (!odd_parity_ok(shift_r, dat_sync_r)) begin
                        frame_err_s = 1'b1;
                        state_nx_s  = ST_IDLE;
                    end else begin
                        state_nx_s = ST_STOP;
                    end
`else
                    state_nx_s = ST_STOP;
`endif
                end
                ST_STOP: begin
                    state_nx_s = ST_IDLE;
                    if (!dat_sync_r) begin
                        frame_err_s = 1'b1;
                    end else begin
                        byte_ok_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Sequence assembly: decides whether a good byte extends the sequence or completes an event.
    always_comb begin
        acc_nx_s    = acc_r;
        seq_nx_s    = seq_r;
        pause_nx_s  = pause_r;
        pcnt_nx_s   = pcnt_r;
        key_nx_s    = ps2_key_r;
        err_nx_s    = 1'b0;
        acc_shift_s = {acc_r[55:0], shift_r};
        hold_s      = (shift_r == 8'hE0) || (shift_r == 8'hF0) ||
                      (acc_shift_s[15:0] == 16'hE012) ||
                      (acc_shift_s[23:0] == 24'hE0F07C);
        if (timeout_s || frame_err_s) begin
            acc_nx_s   = 64'h0;
            seq_nx_s   = 1'b0;
            pause_nx_s = 1'b0;
            pcnt_nx_s  = 3'd0;
            err_nx_s   = 1'b1;
        end else if (byte_ok_s) begin
            if (pause_r) begin
                if (pcnt_r == 3'd7) begin
                    key_nx_s   = {~ps2_key_r[64], acc_shift_s};
                    acc_nx_s   = 64'h0;
                    seq_nx_s   = 1'b0;
                    pause_nx_s = 1'b0;
                    pcnt_nx_s  = 3'd0;
                end else begin
                    acc_nx_s  = acc_shift_s;
                    pcnt_nx_s = pcnt_r + 3'd1;
                end
            end else if (shift_r == 8'hE1) begin
                acc_nx_s   = acc_shift_s;
                seq_nx_s   = 1'b1;
                pause_nx_s = 1'b1;
                pcnt_nx_s  = 3'd1;
            end else if (hold_s) begin
                acc_nx_s = acc_shift_s;
                seq_nx_s = 1'b1;
            end else begin
                key_nx_s   = {~ps2_key_r[64], acc_shift_s};
                acc_nx_s   = 64'h0;
                seq_nx_s   = 1'b0;
                pause_nx_s = 1'b0;
                pcnt_nx_s  = 3'd0;
            end
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Timeout counter: cleared by any strobe, counts only while a frame or sequence is open.
    always_comb begin
        to_cnt_nx_s = to_cnt_r;
        if (!busy_r || strobe_s || timeout_s) begin
            to_cnt_nx_s = {TW{1'b0}};
        end else if (to_cnt_r != TO_LIMIT) begin
            to_cnt_nx_s = to_cnt_r + TO_ONE;
        end else begin
            to_cnt_nx_s = to_cnt_r;
        end
    end

    assign busy_nx_s = (state_nx_s != ST_IDLE) || seq_nx_s;

    // State, accumulator and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            acc_r     <= 64'h0;
            seq_r     <= 1'b0;
            pause_r   <= 1'b0;
            pcnt_r    <= 3'd0;
            ps2_key_r <= 65'h0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            to_cnt_r  <= {TW{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
            acc_r     <= acc_nx_s;
            seq_r     <= seq_nx_s;
            pause_r   <= pause_nx_s;
            pcnt_r    <= pcnt_nx_s;
            ps2_key_r <= key_nx_s;
            err_r     <= err_nx_s;
            busy_r    <= busy_nx_s;
            to_cnt_r  <= to_cnt_nx_s;
        end
    end

    assign ps2_key = ps2_key_r;
    assign err     = err_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_ps2_key_framer.sv
// Testbench for ps2_key_framer: directed and randomized PS/2 frames checked
// against a queue-based model of the key-sequence completion rules.
module tb_ps2_key_framer;

    localparam int FILT = 8;
    localparam int TO   = 20000;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ps2_clk_in;
    logic        ps2_dat_in;
    logic [64:0] ps2_key;
    logic        err;
    logic        busy;

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;
    int exp_err = 0;

    logic [64:0] exp_key;
    logic [7:0]  seq_q[$];
    logic        err_prev = 1'b0;
    logic        tog_prev = 1'b0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_framer #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_key    (ps2_key),
        .err        (err),
        .busy       (busy)
    );

    // Monitor: err pulses are single-cycle, busy is low whenever the toggle changes.
    always @(negedge clk_sys) begin
        if (err === 1'b1) begin
            err_cnt = err_cnt + 1;
            checks  = checks + 1;
            if (err_prev === 1'b1) begin
                errors = errors + 1;
                $display("FAIL err_width: err high %0d consecutive samples, required 1", 2);
            end
        end
        if (ps2_key[64] !== tog_prev) begin
            checks = checks + 1;
            if (busy !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL busy_at_event: busy=%b when toggle changed, required 0", busy);
            end
        end
        err_prev = err;
        tog_prev = ps2_key[64];
    end

    // Reference model: a byte queue holding the open sequence; completion from the key rules.
    task automatic model_push(input logic [7:0] b);
        int          n;
        int          pidx;
        logic        done;
        logic [63:0] v;
        seq_q.push_back(b);
        n    = seq_q.size();
        pidx = -1;
        for (int i = 0; i < n; i++) begin
            if (pidx < 0 && seq_q[i] == 8'hE1) pidx = i;
        end
        if (pidx >= 0)
            done = ((n - pidx) == 8);
        else if (b == 8'hE0 || b == 8'hF0)
            done = 1'b0;
        else if (n >= 2 && seq_q[n-2] == 8'hE0 && b == 8'h12)
            done = 1'b0;
        else if (n >= 3 && seq_q[n-3] == 8'hE0 && seq_q[n-2] == 8'hF0 && b == 8'h7C)
            done = 1'b0;
        else
            done = 1'b1;
        if (done) begin
            v = 64'h0;
            for (int i = ((n > 8) ? n - 8 : 0); i < n; i++) v = {v[55:0], seq_q[i]};
            exp_key = {~exp_key[64], v};
            seq_q.delete();
        end
    endtask

    // Drive one 11-bit device-to-host frame, then let the receiver settle.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_val);
        logic [10:0] bits;
        int          hp;
        hp   = $urandom_range(16, 20);
        bits = {stop_val, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk_sys);
            ps2_dat_in = bits[i];
            repeat (hp) @(posedge clk_sys);
            ps2_clk_in = 1'b0;
            repeat (hp) @(posedge clk_sys);
            ps2_clk_in = 1'b1;
        end
        ps2_dat_in = 1'b1;
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
    endtask

    // Short low spike on the clock line; the filter must swallow it.
    task automatic glitch();
        @(posedge clk_sys);
        ps2_dat_in = 1'b0;
        ps2_clk_in = 1'b0;
        repeat ($urandom_range(1, FILT - 3)) @(posedge clk_sys);
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        repeat (20) @(posedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        exp_key    = 65'h0;
        seq_q.delete();
        repeat (4) @(posedge clk_sys);
        @(negedge clk_sys);
        checks = checks + 1;
        if (ps2_key !== 65'h0) begin
            errors = errors + 1;
            $display("FAIL reset_key: got %h want %h", ps2_key, 65'h0);
        end
        checks = checks + 1;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_flags: err=%b busy=%b want 0 0", err, busy);
        end
        reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);
    endtask

    task automatic test_directed();
        logic [7:0]  s[$];
        logic [63:0] want;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin s = '{8'h1C}; want = 64'h1C; end
                1: begin s = '{8'hF0, 8'h1C}; want = 64'hF01C; end
                2: begin s = '{8'hE0, 8'h12, 8'hE0, 8'h7C}; want = 64'hE012E07C; end
                3: begin s = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12}; want = 64'hE0F07CE0F012; end
                4: begin s = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
                         want = 64'hE11477E1F014F077; end
                default: begin
                    s = '{8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'h1C};
                    want = 64'hE0E0E0E0E0E0E01C;
                end
            endcase
            foreach (s[i]) begin
                send_frame(s[i], 1'b0, 1'b1);
                model_push(s[i]);
                checks = checks + 1;
                if (ps2_key !== exp_key) begin
                    errors = errors + 1;
                    $display("FAIL directed%0d_key byte %0d: got %h want %h", k, i, ps2_key, exp_key);
                end
                checks = checks + 1;
                if (busy !== (seq_q.size() != 0)) begin
                    errors = errors + 1;
                    $display("FAIL directed%0d_busy byte %0d: got %b want %b", k, i, busy, seq_q.size() != 0);
                end
            end
            checks = checks + 1;
            if (ps2_key[63:0] !== want) begin
                errors = errors + 1;
                $display("FAIL directed%0d_final: got %h want %h", k, ps2_key[63:0], want);
            end
            if (k == 4) begin
                checks = checks + 1;
                if (ps2_key[63:24] === 40'h0) begin
                    errors = errors + 1;
                    $display("FAIL pause_upper: got %h want nonzero", ps2_key[63:24]);
                end
            end
            checks = checks + 1;
            if (err_cnt !== exp_err) begin
                errors = errors + 1;
                $display("FAIL directed%0d_err: got %0d pulses want %0d", k, err_cnt, exp_err);
            end
        end
    endtask

    task automatic test_frame_errors();
        // Parity flip on an otherwise plain make code.
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        exp_err = exp_err + 1;
`else
        model_push(8'h1C);
`endif
        checks = checks + 1;
        if (ps2_key !== exp_key || err_cnt !== exp_err) begin
            errors = errors + 1;
            $display("FAIL parity: key %h err %0d want key %h err %0d", ps2_key, err_cnt, exp_key, exp_err);
        end
        // Prefix, then a frame with a bad stop bit: prefix must be discarded.
        send_frame(8'hE0, 1'b0, 1'b1);
        model_push(8'hE0);
        send_frame(8'h1C, 1'b0, 1'b0);
        exp_err = exp_err + 1;
        seq_q.delete();
        checks = checks + 1;
        if (ps2_key !== exp_key || err_cnt !== exp_err || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL stop_bit: key %h err %0d busy %b want key %h err %0d busy 0",
                     ps2_key, err_cnt, busy, exp_key, exp_err);
        end
        send_frame(8'h75, 1'b0, 1'b1);
        model_push(8'h75);
        checks = checks + 1;
        if (ps2_key !== exp_key || ps2_key[63:0] !== 64'h75) begin
            errors = errors + 1;
            $display("FAIL after_stop_err: got %h want %h", ps2_key, exp_key);
        end
    endtask

    task automatic test_timeout();
        int waited;
        send_frame(8'hE0, 1'b0, 1'b1);
        model_push(8'hE0);
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL timeout_busy_open: got %b want 1", busy);
        end
        repeat (TO - 300) @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        checks = checks + 1;
        if (err_cnt !== exp_err || busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL timeout_early: err %0d busy %b want err %0d busy 1", err_cnt, busy, exp_err);
        end
        waited = 0;
        while (err_cnt == exp_err && waited < 600) begin
            @(negedge clk_sys);
            #1;
            waited = waited + 1;
        end
        exp_err = exp_err + 1;
        seq_q.delete();
        checks = checks + 1;
        if (err_cnt !== exp_err) begin
            errors = errors + 1;
            $display("FAIL timeout_err: got %0d pulses want %0d", err_cnt, exp_err);
        end
        checks = checks + 1;
        if (busy !== 1'b0 || ps2_key !== exp_key) begin
            errors = errors + 1;
            $display("FAIL timeout_state: busy %b key %h want busy 0 key %h", busy, ps2_key, exp_key);
        end
        send_frame(8'h75, 1'b0, 1'b1);
        model_push(8'h75);
        checks = checks + 1;
        if (ps2_key !== exp_key || ps2_key[63:0] !== 64'h75) begin
            errors = errors + 1;
            $display("FAIL after_timeout: got %h want %h", ps2_key, exp_key);
        end
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] b;
        for (int k = 0; k < 14; k++) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0 || b == 8'hE1);
            case ($urandom_range(0, 6))
                0: s = '{b};
                1: s = '{8'hF0, b};
                2: begin if (b == 8'h12) b = 8'h11; s = '{8'hE0, b}; end
                3: begin if (b == 8'h7C) b = 8'h7B; s = '{8'hE0, 8'hF0, b}; end
                4: s = '{8'hE0, 8'h12, 8'hE0, 8'h7C};
                5: s = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12};
                default: s = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            endcase
            foreach (s[i]) begin
                if ($urandom_range(0, 3) == 0) glitch();
                send_frame(s[i], 1'b0, 1'b1);
                model_push(s[i]);
                checks = checks + 1;
                if (ps2_key !== exp_key || busy !== (seq_q.size() != 0)) begin
                    errors = errors + 1;
                    $display("FAIL random%0d byte %0d (%h): key %h busy %b want key %h busy %b",
                             k, i, s[i], ps2_key, busy, exp_key, seq_q.size() != 0);
                end
            end
        end
        checks = checks + 1;
        if (err_cnt !== exp_err) begin
            errors = errors + 1;
            $display("FAIL random_err: got %0d pulses want %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] bits;
        bits = 5'b10100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_sys);
            ps2_dat_in = bits[i];
            repeat (18) @(posedge clk_sys);
            ps2_clk_in = 1'b0;
            repeat (18) @(posedge clk_sys);
            ps2_clk_in = 1'b1;
        end
        ps2_dat_in = 1'b1;
        @(negedge clk_sys);
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL midframe_busy: got %b want 1", busy);
        end
        reset_n = 1'b0;
        exp_key = 65'h0;
        seq_q.delete();
        #1;
        checks = checks + 1;
        if (ps2_key !== 65'h0 || busy !== 1'b0 || err !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midframe_reset: key %h busy %b err %b want 0 0 0", ps2_key, busy, err);
        end
        repeat (4) @(posedge clk_sys);
        reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        send_frame(8'h1C, 1'b0, 1'b1);
        model_push(8'h1C);
        checks = checks + 1;
        if (ps2_key !== exp_key || ps2_key !== {1'b1, 64'h1C}) begin
            errors = errors + 1;
            $display("FAIL after_reset_event: got %h want %h", ps2_key, exp_key);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_frame_errors();
        test_timeout();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
